// File: rtl/ustaw_czas_ctrl_pkg.sv
// Shared definitions for the time-setting controller: FSM states, digit-select
// encoding and the BCD wrap limits for hours and minutes.
package ustaw_czas_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        LOAD    = 2'd3
    } state_t;

    localparam logic [1:0] SEL_HR2  = 2'b00;
    localparam logic [1:0] SEL_HR1  = 2'b01;
    localparam logic [1:0] SEL_MIN2 = 2'b10;
    localparam logic [1:0] SEL_MIN1 = 2'b11;

    localparam logic [7:0] HR_LIMIT  = 8'h23;
    localparam logic [7:0] MIN_LIMIT = 8'h59;

endpackage

// File: rtl/ustaw_czas_ctrl_bcd_inc_mod.sv
// Two-digit BCD incrementer that wraps to 00 once the value reaches LIMIT.
module bcd_inc_mod #(
    parameter logic [7:0] LIMIT = 8'h59
) (
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [3:0] tens_next,
    output logic [3:0] units_next
);

    // Digit ordering makes a plain byte compare valid for BCD; anything at or
    // above the limit (including odd values copied in from outside) wraps.
    always_comb begin
        tens_next  = tens;
        units_next = units;
        if ({tens, units} >= LIMIT) begin
            tens_next  = 4'd0;
            units_next = 4'd0;
        end else if (units >= 4'd9) begin
            tens_next  = tens + 4'd1;
            units_next = 4'd0;
        end else begin
            units_next = units + 4'd1;
        end
    end

endmodule

// File: rtl/ustaw_czas_ctrl.sv
// Clock time-setting controller: mode/inc button FSM, display refresh scan and
// optional edit-digit blinking (enabled by the USTAW_CZAS_BLINK_EN macro).
module ustaw_czas_ctrl
    import ustaw_czas_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic [3:0] live_hr2_i,
    input  logic [3:0] live_hr1_i,
    input  logic [3:0] live_min2_i,
    input  logic [3:0] live_min1_i,
    output logic [3:0] hr2_o,
    output logic [3:0] hr1_o,
    output logic [3:0] min2_o,
    output logic [3:0] min1_o,
    output logic [1:0] odswiezanie_o,
    output logic       blank_o,
    output logic       load_o
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    state_t     state, state_next;
    logic       mode_prev, inc_prev;
    logic       mode_press, inc_press, inc_accept;
    logic [3:0] edit_hr2, edit_hr1, edit_min2, edit_min1;
    logic [3:0] hr2_inc, hr1_inc, min2_inc, min1_inc;
    logic [RW-1:0] ref_cnt;
    logic [1:0] sel;
    logic       ref_tc;

    assign mode_press = btn_mode_i & ~mode_prev;
    assign inc_press  = btn_inc_i & ~inc_prev;
    assign inc_accept = inc_press & ~mode_press & ((state == SET_HR) | (state == SET_MIN));
    assign ref_tc     = (ref_cnt == REF_LAST);

    bcd_inc_mod #(.LIMIT(HR_LIMIT)) u_hr_inc (
        .tens(edit_hr2), .units(edit_hr1), .tens_next(hr2_inc), .units_next(hr1_inc)
    );

    bcd_inc_mod #(.LIMIT(MIN_LIMIT)) u_min_inc (
        .tens(edit_min2), .units(edit_min1), .tens_next(min2_inc), .units_next(min1_inc)
    );

    // State, button history and refresh scan registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            mode_prev <= 1'b1;
            inc_prev  <= 1'b1;
            ref_cnt   <= '0;
            sel       <= SEL_HR2;
        end else begin
            state     <= state_next;
            mode_prev <= btn_mode_i;
            inc_prev  <= btn_inc_i;
            if (ref_tc) begin
                ref_cnt <= '0;
                sel     <= sel + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end
        end
    end

    // Next-state logic; a mode press always takes precedence over inc.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (mode_press) state_next = SET_HR;
            SET_HR:  if (mode_press) state_next = SET_MIN;
            SET_MIN: if (mode_press) state_next = LOAD;
            LOAD:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Edit registers: snapshot on entry to editing, BCD increment on accepted inc.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edit_hr2  <= 4'd0;
            edit_hr1  <= 4'd0;
            edit_min2 <= 4'd0;
            edit_min1 <= 4'd0;
        end else if (state == RUN && mode_press) begin
            edit_hr2  <= live_hr2_i;
            edit_hr1  <= live_hr1_i;
            edit_min2 <= live_min2_i;
            edit_min1 <= live_min1_i;
        end else if (inc_accept && state == SET_HR) begin
            edit_hr2 <= hr2_inc;
            edit_hr1 <= hr1_inc;
        end else if (inc_accept && state == SET_MIN) begin
            edit_min2 <= min2_inc;
            edit_min1 <= min1_inc;
        end else begin
            edit_hr2  <= edit_hr2;
            edit_hr1  <= edit_hr1;
            edit_min2 <= edit_min2;
            edit_min1 <= edit_min1;
        end
    end

    // In RUN the display follows the live clock without a register stage.
    always_comb begin
        if (state == RUN) begin
            hr2_o  = live_hr2_i;
            hr1_o  = live_hr1_i;
            min2_o = live_min2_i;
            min1_o = live_min1_i;
        end else begin
            hr2_o  = edit_hr2;
            hr1_o  = edit_hr1;
            min2_o = edit_min2;
            min1_o = edit_min1;
        end
    end

    assign load_o        = (state == LOAD);
    assign odswiezanie_o = sel;

`ifdef USTAW_CZAS_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          blink_clr;

    assign blink_clr = inc_accept |
                       ((state_next != state) & ((state_next == SET_HR) | (state_next == SET_MIN)));

    // Blink phase advances on refresh wraps; restarts visible on edits.
    always_ff @(posedge clk_i) begin
        if (rst_i || blink_clr) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (ref_tc) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end else begin
            blink_cnt   <= blink_cnt;
            blink_phase <= blink_phase;
        end
    end

    // Blank only the field under edit, and only in the hidden phase.
    always_comb begin
        if (blink_phase && state == SET_HR && !sel[1]) begin
            blank_o = 1'b1;
        end else if (blink_phase && state == SET_MIN && sel[1]) begin
            blank_o = 1'b1;
        end else begin
            blank_o = 1'b0;
        end
    end
`else
    assign blank_o = 1'b0;
`endif

endmodule
